// File: rtl/tics_pkg.sv
// Shared constants for the tics_timer block: mode encodings and default widths.
// The optional prescaler is enabled by defining TICS_TIMER_PRESCALE_EN.
package tics_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int TICS_WIDTH_DEF = 8;
    localparam int TICS_PRE_W_DEF = 4;

    typedef enum logic [1:0] {
        CTL_LOAD  = 2'd0,
        CTL_STOP  = 2'd1,
        CTL_START = 2'd2,
        CTL_STEP  = 2'd3
    } ctl_e;

    // Resolve the per-cycle control action; lower enum value wins.
    function automatic ctl_e ctl_select(input logic load, input logic stop,
                                        input logic start, input logic running);
        ctl_e sel;
        if (load)                   sel = CTL_LOAD;
        else if (stop)              sel = CTL_STOP;
        else if (start && !running) sel = CTL_START;
        else                        sel = CTL_STEP;
        return sel;
    endfunction

endpackage

// File: rtl/tics_prescaler.sv
// Step-strobe divider for tics_timer: strobe fires once every div+1 enabled
// cycles, and the phase restarts from zero whenever clr is high.
module tics_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             strobe
);

    logic [PRE_W-1:0] cnt_q, cnt_d;
    logic             at_end;

    assign at_end = (cnt_q == div);
    assign strobe = en && !clr && at_end;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en)  cnt_d = '0;
        else if (at_end) cnt_d = '0;
        else             cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tics_timer.sv
// Down-counting timer with reload, one-shot/periodic modes, registered tick
// pulse and a toggle flop. Define TICS_TIMER_PRESCALE_EN to enable prescaling.
module tics_timer
    import tics_pkg::*;
#(
    parameter int WIDTH = TICS_WIDTH_DEF,
    parameter int PRE_W = TICS_PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [PRE_W-1:0] prescale_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             tick_o,
    output logic             q_o,
    output logic             qn_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic             tog_q, tog_d;
    logic             strobe;
    ctl_e             ctl;

`ifdef TICS_TIMER_PRESCALE_EN
    logic presc_clr;

    assign presc_clr = load_i || start_i || stop_i || !run_q;

    tics_prescaler #(.PRE_W(PRE_W)) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clr    (presc_clr),
        .en     (run_q),
        .div    (prescale_i),
        .strobe (strobe)
    );
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale_i;
    assign strobe          = 1'b1;
`endif

    assign ctl = ctl_select(load_i, stop_i, start_i, run_q);

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        run_d    = run_q;
        tick_d   = 1'b0;
        tog_d    = tog_q;
        case (ctl)
            CTL_LOAD: begin
                count_d  = load_val_i;
                reload_d = load_val_i;
                run_d    = 1'b0;
            end
            CTL_STOP:  run_d = 1'b0;
            CTL_START: run_d = 1'b1;
            default: begin
                if (run_q && strobe) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        // Terminal step: pulse, toggle, then reload or park at zero.
                        tick_d = 1'b1;
                        tog_d  = ~tog_q;
                        if (mode_i == MODE_PERIODIC) count_d = reload_q;
                        else                         run_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            run_q    <= 1'b0;
            tick_q   <= 1'b0;
            tog_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            run_q    <= run_d;
            tick_q   <= tick_d;
            tog_q    <= tog_d;
        end
    end

    assign count_o = count_q;
    assign busy_o  = run_q;
    assign tick_o  = tick_q;
    assign q_o     = tog_q;
    assign qn_o    = ~tog_q;

endmodule

// File: doc/tics_timer.md
TICS_TIMER -- requirements
Module: tics_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and reload width (WIDTH >= 2).
REQ-002 SHALL have parameter PRE_W, default 4, prescaler width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load_i  input  1  load count and reload registers from load_val_i.
REQ-006 SHALL have port load_val_i  input  WIDTH  reload value.
REQ-007 SHALL have port start_i  input  1  set running.
REQ-008 SHALL have port stop_i  input  1  clear running.
REQ-009 SHALL have port mode_i  input  1  0 = one-shot, 1 = periodic; sampled every cycle.
REQ-010 SHALL have port prescale_i  input  PRE_W  divide ratio minus one.
REQ-011 SHALL have port count_o  output  WIDTH  current count.
REQ-012 SHALL have port busy_o  output  1  running flag.
REQ-013 SHALL have port tick_o  output  1  one-cycle terminal-count pulse, registered.
REQ-014 SHALL have ports q_o and qn_o  output  1 each  complementary toggle flop, toggled per tick.

Function
REQ-015 Per-cycle control priority SHALL be load_i > stop_i > start_i > decrement.
REQ-016 On load_i, count and reload SHALL take load_val_i, running SHALL clear, and tick_o SHALL be 0 next cycle.
REQ-017 On start_i while idle, running SHALL set; start_i while running SHALL have no effect.
REQ-018 A step SHALL occur when running and the step strobe is 1; the strobe is 1 every cycle when prescaling is absent.
REQ-019 Step with count != 0 SHALL decrement count by 1 and leave tick_o 0.
REQ-020 Step with count == 0 SHALL assert tick_o the next cycle for exactly one cycle and toggle q_o/qn_o.
REQ-021 At terminal in periodic mode, count SHALL reload from reload and running SHALL stay set; reload 0 SHALL give a tick every step.
REQ-022 At terminal in one-shot mode, count SHALL stay 0 and running SHALL clear.
REQ-023 Period SHALL be reload+1 steps; from start_i with count N, the first tick_o SHALL be seen N+1 steps later.
REQ-024 qn_o SHALL always equal the inverse of q_o and SHALL never be equal to it in any cycle.
REQ-025 busy_o SHALL equal running and count_o SHALL equal count, with no combinational paths from inputs.

Reset
REQ-026 While rst is high, the block SHALL force count 0, reload 0, running 0, tick_o 0, q_o 0, qn_o 1, and prescaler 0, regardless of clk.
REQ-027 Asserting rst mid-count SHALL abort the count with no tick; the first edge after release SHALL behave per REQ-015.

Configuration
REQ-028 Macro TICS_TIMER_PRESCALE_EN defined: the step strobe SHALL be 1 every prescale_i+1 running cycles, and the prescaler SHALL clear on load_i, start_i, stop_i, and while idle.
REQ-029 Macro TICS_TIMER_PRESCALE_EN undefined: the prescale_i port SHALL remain but be ignored, and the strobe SHALL be constant 1.

Structure
REQ-030 Package tics_pkg SHALL hold the mode constants MODE_ONESHOT=0 and MODE_PERIODIC=1 and the default WIDTH/PRE_W constants.
REQ-031 The prescaler SHALL be sub-module tics_prescaler (PRE_W, clk, rst, clr, en, div, strobe), instantiated only under TICS_TIMER_PRESCALE_EN.

Verification
REQ-032 Reset test: assert rst mid-run -> all outputs are at REQ-026 values immediately; after release, count_o=0 and busy_o=0.
REQ-033 Periodic test: WIDTH=8, load 3, start, mode 1, no prescale -> tick_o pulses every 4 cycles, and q_o toggles on each pulse.
REQ-034 One-shot test: load 5, start, mode 0 -> a single tick_o 6 cycles after start, then busy_o=0 and count_o=0.
REQ-035 Priority test: load_i, stop_i, and start_i together at the terminal cycle -> count_o=load_val_i, busy_o=0, no tick.
REQ-036 Prescale test (macro on): prescale_i=2, load 1, periodic -> tick_o every 6 cycles; with macro off -> every 2 cycles.
REQ-037 Edge test: reload 0, periodic -> tick_o high every cycle after start, q_o alternating, and qn_o = ~q_o on all cycles.
